// File: rtl/pic_vectored.sv
// pic_vectored: vectored programmable interrupt controller.
//
// Requests are captured into a pending vector: rising-edge detection for
// channels with EDGE_MODE[i]=1, level sampling for EDGE_MODE[i]=0. Pending
// is captured regardless of mask. The lowest-index unmasked pending channel
// is presented to the CPU with a vector of VECTOR_BASE + index. Each
// transaction follows present -> acknowledge -> service -> end-of-interrupt.
//
// Parameters:
//   NUM_INT      number of interrupt channels (2..16)
//   VECTOR_BASE  vector of channel 0
//   EDGE_MODE    per channel: 1 = rising edge, 0 = level
// Ports:
//   clock          sole clock, rising edge
//   reset          asynchronous active-high reset
//   clr            synchronous clear of pending and in-service state
//   int_req        request lines (synchronous to clock)
//   int_mask       1 = channel excluded from arbitration
//   int_ack        CPU acknowledge of the presented interrupt
//   int_eoi        CPU end-of-interrupt
//   interrupt      registered interrupt request to CPU
//   interrupt_type registered vector of presented/serviced channel
//   in_service     one-hot channel currently in service
module pic_vectored #(
  parameter int unsigned        NUM_INT     = 8,
  parameter logic [7:0]         VECTOR_BASE = 8'h00,
  parameter logic [NUM_INT-1:0] EDGE_MODE   = '1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               clr,
  input  logic [NUM_INT-1:0] int_req,
  input  logic [NUM_INT-1:0] int_mask,
  input  logic               int_ack,
  input  logic               int_eoi,
  output logic               interrupt,
  output logic [7:0]         interrupt_type,
  output logic [NUM_INT-1:0] in_service
);

  localparam int unsigned IDX_W = $clog2(NUM_INT);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ASSERT  = 2'd1;
  localparam logic [1:0] ST_SERVICE = 2'd2;

  logic [1:0]         state;
  logic [NUM_INT-1:0] prev;
  logic [NUM_INT-1:0] pending;
  logic [NUM_INT-1:0] pending_nxt;
  logic [NUM_INT-1:0] set_vec;
  logic [NUM_INT-1:0] ack_clear;
  logic [NUM_INT-1:0] eligible;
  logic [NUM_INT-1:0] winner_onehot;
  logic [IDX_W-1:0]   winner;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_valid;

  // Edge channels see a set only when prev is low; level channels ignore prev.
  always_comb begin
    set_vec = int_req & ~(prev & EDGE_MODE);
  end

  always_comb begin
    eligible = pending & ~int_mask;
  end

  // Lowest index wins: scan downwards so the last hit is the lowest.
  always_comb begin
    arb_valid = 1'b0;
    arb_idx   = '0;
    for (int unsigned i = NUM_INT; i > 0; i--) begin
      if (eligible[i-1]) begin
        arb_valid = 1'b1;
        arb_idx   = IDX_W'(i - 1);
      end
    end
  end

  always_comb begin
    winner_onehot = {{(NUM_INT-1){1'b0}}, 1'b1} << winner;
  end

  // The ack clear is applied before the OR with new sets, so a same-edge
  // set on the acknowledged channel keeps it pending.
  always_comb begin
    ack_clear   = '0;
    if (state == ST_ASSERT && int_ack) begin
      ack_clear = winner_onehot;
    end
    pending_nxt = (pending & ~ack_clear) | set_vec;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev           <= '1;
      pending        <= '0;
      in_service     <= '0;
      interrupt      <= 1'b0;
      interrupt_type <= VECTOR_BASE;
      winner         <= '0;
      state          <= ST_IDLE;
    end else begin
      // prev keeps tracking int_req even during clr, so a line that is high
      // through a clear does not look like a fresh edge afterwards.
      prev <= int_req;
      if (clr) begin
        pending        <= '0;
        in_service     <= '0;
        interrupt      <= 1'b0;
        interrupt_type <= VECTOR_BASE;
        state          <= ST_IDLE;
      end else begin
        pending <= pending_nxt;
        case (state)
          ST_IDLE: begin
            if (arb_valid) begin
              winner         <= arb_idx;
              interrupt      <= 1'b1;
              interrupt_type <= VECTOR_BASE + 8'(arb_idx);
              state          <= ST_ASSERT;
            end
          end
          ST_ASSERT: begin
            if (int_ack) begin
              interrupt  <= 1'b0;
              in_service <= winner_onehot;
              state      <= ST_SERVICE;
            end else if (int_mask[winner]) begin
              // Withdrawn by mask: pending[winner] stays set for later.
              interrupt <= 1'b0;
              state     <= ST_IDLE;
            end
          end
          ST_SERVICE: begin
            if (int_eoi) begin
              in_service <= '0;
              state      <= ST_IDLE;
            end
          end
          default: begin
            interrupt <= 1'b0;
            state     <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pic_vectored.sv
// Testbench for pic_vectored: NUM_INT=8, VECTOR_BASE=8'h20, channel 0 level
// triggered, channels 1..7 edge triggered. Directed stimulus with literal
// expectations plus a behavioural model compared every cycle.
module tb_pic_vectored;

  localparam logic [7:0] BASE = 8'h20;
  localparam logic [7:0] EM   = 8'hFE;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       clr = 1'b0;
  logic [7:0] int_req = '0;
  logic [7:0] int_mask = '0;
  logic       int_ack = 1'b0;
  logic       int_eoi = 1'b0;
  logic       interrupt;
  logic [7:0] interrupt_type;
  logic [7:0] in_service;

  int n_chk = 0;
  int n_pass = 0;

  pic_vectored #(
    .NUM_INT    (8),
    .VECTOR_BASE(BASE),
    .EDGE_MODE  (EM)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .clr           (clr),
    .int_req       (int_req),
    .int_mask      (int_mask),
    .int_ack       (int_ack),
    .int_eoi       (int_eoi),
    .interrupt     (interrupt),
    .interrupt_type(interrupt_type),
    .in_service    (in_service)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  // Behavioural model: a channel is "shown" to the CPU, then "busy" in
  // service; pending requests wait in a bit set.
  bit [7:0]   m_prev, m_pend, m_isv;
  bit         m_shown, m_busy;
  int         m_cur;
  logic [7:0] m_type;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_prev = '1; m_pend = '0; m_isv = '0;
      m_shown = 0; m_busy = 0; m_cur = 0; m_type = BASE;
    end else begin : model_step
      bit [7:0] fresh;
      bit [7:0] old;
      bit       found;
      for (int i = 0; i < 8; i++)
        fresh[i] = int_req[i] && (!EM[i] || !m_prev[i]);
      old = m_pend;
      if (clr) begin
        m_pend = '0; m_isv = '0; m_shown = 0; m_busy = 0; m_type = BASE;
      end else begin
        if (m_shown) begin
          if (int_ack) begin
            old[m_cur] = 1'b0;
            m_isv = 8'(1 << m_cur);
            m_shown = 0;
            m_busy = 1;
          end else if (int_mask[m_cur]) begin
            m_shown = 0;
          end
        end else if (m_busy) begin
          if (int_eoi) begin
            m_isv = '0;
            m_busy = 0;
          end
        end else begin
          found = 0;
          for (int i = 0; i < 8; i++) begin
            if (!found && old[i] && !int_mask[i]) begin
              found = 1;
              m_cur = i;
              m_shown = 1;
              m_type = BASE + 8'(i);
            end
          end
        end
        m_pend = old | fresh;
      end
      m_prev = int_req;
    end
  end

  always @(negedge clock) begin
    chk("model_interrupt", {15'd0, interrupt}, {15'd0, m_shown});
    chk("model_type", {8'd0, interrupt_type}, {8'd0, m_type});
    chk("model_in_service", {8'd0, in_service}, {8'd0, m_isv});
  end

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic serve_and_end();
    int_ack = 1; tick(); int_ack = 0;
    int_eoi = 1; tick(); int_eoi = 0;
  endtask

  initial begin
    tick(); tick();
    chk("reset_interrupt", {15'd0, interrupt}, 16'd0);
    chk("reset_type", {8'd0, interrupt_type}, 16'h0020);
    chk("reset_in_service", {8'd0, in_service}, 16'd0);
    reset = 0;
    tick();

    // Single pulse on channel 3, two-edge latency.
    int_req = 8'h08; tick(); int_req = 0;
    chk("c3_not_yet", {15'd0, interrupt}, 16'd0);
    tick();
    chk("c3_interrupt", {15'd0, interrupt}, 16'd1);
    chk("c3_type", {8'd0, interrupt_type}, 16'h0023);
    int_ack = 1; tick(); int_ack = 0;
    chk("c3_ack_interrupt", {15'd0, interrupt}, 16'd0);
    chk("c3_in_service", {8'd0, in_service}, 16'h0008);
    int_eoi = 1; tick(); int_eoi = 0;
    chk("c3_eoi_in_service", {8'd0, in_service}, 16'd0);
    tick();
    chk("c3_no_repeat", {15'd0, interrupt}, 16'd0);

    // Channels 5 and 2 together: 2 first, then 5 right after eoi.
    int_req = 8'h24; tick(); int_req = 0; tick();
    chk("pri_type_first", {8'd0, interrupt_type}, 16'h0022);
    int_ack = 1; tick(); int_ack = 0;
    chk("pri_in_service", {8'd0, in_service}, 16'h0004);
    int_eoi = 1; tick(); int_eoi = 0;
    chk("pri_idle_gap", {15'd0, interrupt}, 16'd0);
    tick();
    chk("pri_second_int", {15'd0, interrupt}, 16'd1);
    chk("pri_type_second", {8'd0, interrupt_type}, 16'h0025);
    serve_and_end();

    // Masked pulse stays pending until unmasked.
    int_mask = 8'h02; int_req = 8'h02; tick(); int_req = 0; tick(); tick();
    chk("mask_blocks", {15'd0, interrupt}, 16'd0);
    int_mask = 0; tick();
    chk("unmask_type", {8'd0, interrupt_type}, 16'h0021);
    chk("unmask_int", {15'd0, interrupt}, 16'd1);
    serve_and_end();

    // Withdrawal by mask during presentation, then re-presentation.
    int_req = 8'h10; tick(); int_req = 0; tick();
    int_mask = 8'h10; tick();
    chk("withdraw_int", {15'd0, interrupt}, 16'd0);
    chk("withdraw_type_kept", {8'd0, interrupt_type}, 16'h0024);
    int_mask = 0; tick();
    chk("represent_int", {15'd0, interrupt}, 16'd1);
    serve_and_end();

    // Set wins over ack-clear on the same channel.
    int_req = 8'h10; tick(); int_req = 0; tick();
    int_ack = 1; int_req = 8'h10; tick(); int_ack = 0; int_req = 0;
    chk("setwin_in_service", {8'd0, in_service}, 16'h0010);
    int_eoi = 1; tick(); int_eoi = 0; tick();
    chk("setwin_reassert", {15'd0, interrupt}, 16'd1);
    serve_and_end();

    // Level channel 0 held high re-asserts after eoi.
    int_req = 8'h01; tick(); tick();
    chk("level_type", {8'd0, interrupt_type}, 16'h0020);
    serve_and_end(); tick();
    chk("level_reassert", {15'd0, interrupt}, 16'd1);
    int_req = 0; serve_and_end(); tick();
    chk("level_released", {15'd0, interrupt}, 16'd0);

    // Edge channel 6 held high asserts only once.
    int_req = 8'h40; tick(); tick();
    chk("edge_hold_type", {8'd0, interrupt_type}, 16'h0026);
    serve_and_end(); tick(); tick();
    chk("edge_hold_once", {15'd0, interrupt}, 16'd0);
    int_req = 0; tick();

    // Ack/eoi outside their phase are ignored.
    int_req = 8'h80; tick(); int_req = 0; int_eoi = 1; tick(); int_eoi = 0;
    chk("eoi_idle_ignored", {15'd0, interrupt}, 16'd1);
    int_eoi = 1; tick(); int_eoi = 0;
    chk("eoi_assert_ignored", {15'd0, interrupt}, 16'd1);
    int_ack = 1; tick(); tick(); int_ack = 0;
    chk("ack_service_ignored", {8'd0, in_service}, 16'h0080);
    int_eoi = 1; tick(); int_eoi = 0;

    // clr during presentation with two channels pending.
    int_req = 8'h0C; tick(); int_req = 0; tick();
    chk("clr_pre_type", {8'd0, interrupt_type}, 16'h0022);
    clr = 1; int_ack = 1; tick(); clr = 0; int_ack = 0;
    chk("clr_int", {15'd0, interrupt}, 16'd0);
    chk("clr_type", {8'd0, interrupt_type}, 16'h0020);
    chk("clr_in_service", {8'd0, in_service}, 16'd0);
    tick(); tick();
    chk("clr_no_after", {15'd0, interrupt}, 16'd0);
    clr = 1; int_req = 8'h80; tick(); clr = 0; tick(); tick();
    chk("clr_overrides_req", {15'd0, interrupt}, 16'd0);
    int_req = 0; tick();

    // Async reset pulse between edges during service.
    int_req = 8'h02; tick(); int_req = 0; tick();
    int_ack = 1; tick(); int_ack = 0;
    chk("pre_reset_in_service", {8'd0, in_service}, 16'h0002);
    int_req = 8'h08;
    #2 reset = 1;
    #1;
    chk("areset_int", {15'd0, interrupt}, 16'd0);
    chk("areset_type", {8'd0, interrupt_type}, 16'h0020);
    chk("areset_in_service", {8'd0, in_service}, 16'd0);
    #1 reset = 0;
    tick(); tick(); tick();
    chk("post_reset_no_edge", {15'd0, interrupt}, 16'd0);
    int_req = 0; tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pic_vectored.md
PIC_VECTORED -- requirements
Module: pic_vectored

Interface
REQ-001 SHALL have parameter NUM_INT, default 8, number of interrupt channels (legal 2..16).
REQ-002 SHALL have parameter VECTOR_BASE, default 8'h00, type code of channel 0.
REQ-003 SHALL have parameter EDGE_MODE, default all ones (NUM_INT bits), per channel: 1 = rising-edge triggered, 0 = level triggered.
REQ-004 SHALL have port clock  input  1  sole clock, positive edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port clr  input  1  synchronous clear of all pending and in-service state.
REQ-007 SHALL have port int_req  input  NUM_INT  interrupt request lines, already synchronous to clock.
REQ-008 SHALL have port int_mask  input  NUM_INT  1 = channel excluded from arbitration.
REQ-009 SHALL have port int_ack  input  1  CPU acknowledge of the presented interrupt.
REQ-010 SHALL have port int_eoi  input  1  CPU end-of-interrupt.
REQ-011 SHALL have port interrupt  output  1  registered request to CPU.
REQ-012 SHALL have port interrupt_type  output  8  registered vector of the presented or serviced channel.
REQ-013 SHALL have port in_service  output  NUM_INT  one-hot channel currently in service.

Function
REQ-014 SHALL keep a registered previous-sample vector of int_req for edge detection.
REQ-015 SHALL set pending[i] at a clock edge when int_req[i] is high and prev[i] is low (edge channel), or when int_req[i] is high (level channel).
REQ-016 SHALL set pending regardless of int_mask; the mask gates arbitration only.
REQ-017 SHALL implement states IDLE, ASSERT and SERVICE.
REQ-018 In IDLE with any pending & ~int_mask bit set, SHALL select the lowest index as winner, set interrupt=1, set interrupt_type=VECTOR_BASE+index (8-bit wrap) and go to ASSERT, all at the same edge.
REQ-019 Latency SHALL be: int_req edge sampled at edge N, pending=1 after edge N, interrupt=1 after edge N+1.
REQ-020 In ASSERT, interrupt and interrupt_type SHALL hold stable until int_ack or withdrawal.
REQ-021 On int_ack in ASSERT, SHALL clear pending[winner], set in_service[winner], drive interrupt=0 and go to SERVICE.
REQ-022 If int_mask[winner] goes high in ASSERT without int_ack, SHALL drive interrupt=0 and return to IDLE; pending[winner] is kept.
REQ-023 In SERVICE, SHALL present no new interrupt; pending bits continue to accumulate.
REQ-024 On int_eoi in SERVICE, SHALL clear in_service and go to IDLE; arbitration SHALL resume on the next edge.
REQ-025 SHALL ignore int_ack outside ASSERT and int_eoi outside SERVICE.
REQ-026 If a set condition (REQ-015) and the ack clear hit the same channel at the same edge, set SHALL win (pending stays 1).
REQ-027 interrupt_type SHALL retain the last vector in SERVICE and IDLE.
REQ-028 clr=1 at an edge SHALL clear pending, in_service and interrupt, load interrupt_type=VECTOR_BASE and enter IDLE; prev SHALL still sample int_req; clr SHALL override ack, eoi and new requests.

Reset
REQ-029 reset high SHALL immediately force interrupt=0, interrupt_type=VECTOR_BASE, in_service=0, pending=0, state IDLE and prev=all ones, so that a line already high at release is not seen as an edge.
REQ-030 Reset asserted mid-ASSERT or mid-SERVICE SHALL abandon the transaction with no pending state retained.

Verification
REQ-031 NUM_INT=8, VECTOR_BASE=8'h20: pulse int_req[3] -> interrupt=1 two edges later, interrupt_type=8'h23; ack -> in_service=8'h08; eoi -> in_service=0.
REQ-032 int_req[5] and int_req[2] rise together -> type 8'h22 served first; after eoi, type 8'h25 asserted on the following edge.
REQ-033 int_mask[1]=1 with int_req[1] pulsed -> no interrupt; clear mask -> interrupt asserted with type VECTOR_BASE+1 (pending retained).
REQ-034 Level channel 0 held high through ack and eoi -> re-asserted after eoi; edge channel held high -> asserted once only.
REQ-035 clr during ASSERT with two channels pending -> interrupt=0, in_service=0, type=VECTOR_BASE next edge, and no assertion afterwards without a new edge.
REQ-036 Async reset pulse between clock edges during SERVICE -> outputs at reset values before the next edge; int_req held high across release -> no interrupt on an edge channel.
